// File: rtl/reg_file_sb_pkg.sv
// Shared constants and packing helpers for the CPU register file and its scoreboard.
package cpu_rf_pkg;
  localparam int DEF_DATA_W = 32;
  localparam int DEF_ADDR_W = 5;
  localparam int ZERO_REG   = 0;

  // Low bit of port k's field inside a packed multi-port vector.
  function automatic int slice_lo(input int port, input int width);
    return port * width;
  endfunction
endpackage

// File: rtl/reg_file_sb_if.sv
// Writeback, claim and read-port bundle between the pipeline and the register file.
interface reg_file_sb_if
  import cpu_rf_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W,
  parameter int ADDR_W = DEF_ADDR_W,
  parameter int NUM_RD = 2
);
  logic                     Reg_Write;
  logic [ADDR_W-1:0]        W_Addr;
  logic [DATA_W-1:0]        W_Data;
  logic [NUM_RD*ADDR_W-1:0] R_Addr;
  logic [NUM_RD*DATA_W-1:0] R_Data;
  logic [NUM_RD-1:0]        R_Busy;
  logic                     Claim;
  logic [ADDR_W-1:0]        Claim_Addr;
  logic                     Claim_Ack;
  logic [ADDR_W:0]          Busy_Cnt;

  modport master (
    output Reg_Write, W_Addr, W_Data, R_Addr, Claim, Claim_Addr,
    input  R_Data, R_Busy, Claim_Ack, Busy_Cnt
  );

  modport slave (
    input  Reg_Write, W_Addr, W_Data, R_Addr, Claim, Claim_Addr,
    output R_Data, R_Busy, Claim_Ack, Busy_Cnt
  );
endinterface

// File: rtl/reg_file_sb_scoreboard.sv
// Busy-bit scoreboard: claim acceptance, per-port busy lookup and busy-register count.
module rf_scoreboard
  import cpu_rf_pkg::*;
#(
  parameter int ADDR_W = DEF_ADDR_W,
  parameter int NUM_RD = 2,
  parameter int BYPASS = 1
) (
  input  logic                     clk_Regs,
  input  logic                     rst_n,
  input  logic                     wr_en,
  input  logic [ADDR_W-1:0]        w_addr,
  input  logic                     claim,
  input  logic [ADDR_W-1:0]        claim_addr,
  input  logic [NUM_RD*ADDR_W-1:0] r_addr,
  output logic                     claim_ack,
  output logic [NUM_RD-1:0]        r_busy,
  output logic [ADDR_W:0]          busy_cnt
);
  localparam int DEPTH = 2**ADDR_W;
  localparam logic [ADDR_W:0] CNT_MAX = (ADDR_W+1)'(DEPTH - 1);

  logic [DEPTH-1:0] busy_reg;
  logic [ADDR_W:0]  busy_cnt_reg, busy_cnt_next;
  logic             claim_eff_busy, set_en, clr_en;

  // A release in the same cycle frees the register for an immediate re-claim.
  assign claim_eff_busy = busy_reg[claim_addr] && !(wr_en && (w_addr == claim_addr));
  assign claim_ack      = rst_n && claim &&
                          ((claim_addr == ADDR_W'(ZERO_REG)) || !claim_eff_busy);
  assign set_en         = claim_ack && (claim_addr != ADDR_W'(ZERO_REG));
  assign clr_en         = wr_en && busy_reg[w_addr];

  always_comb begin
    busy_cnt_next = busy_cnt_reg;
    if (set_en && !clr_en && busy_cnt_reg != CNT_MAX)
      busy_cnt_next = busy_cnt_reg + (ADDR_W+1)'(1);
    else if (clr_en && !set_en && busy_cnt_reg != '0)
      busy_cnt_next = busy_cnt_reg - (ADDR_W+1)'(1);
  end

  // Claim is applied after release so a same-address pair leaves the bit set.
  always_ff @(posedge clk_Regs) begin
    if (!rst_n) begin
      busy_reg     <= '0;
      busy_cnt_reg <= '0;
    end else begin
      if (wr_en)  busy_reg[w_addr]     <= 1'b0;
      if (set_en) busy_reg[claim_addr] <= 1'b1;
      busy_cnt_reg <= busy_cnt_next;
    end
  end

  always_comb begin
    r_busy = '0;
    for (int k = 0; k < NUM_RD; k++) begin
      logic [ADDR_W-1:0] a;
      a = r_addr[slice_lo(k, ADDR_W) +: ADDR_W];
      r_busy[k] = busy_reg[a] && (a != ADDR_W'(ZERO_REG)) &&
                  !((BYPASS != 0) && wr_en && (w_addr == a));
    end
  end

  assign busy_cnt = busy_cnt_reg;
endmodule

// File: rtl/reg_file_sb.sv
// Parametrised multi-read-port register file with write bypass and busy-bit scoreboard.
module reg_file_sb
  import cpu_rf_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W,
  parameter int ADDR_W = DEF_ADDR_W,
  parameter int NUM_RD = 2,
  parameter int BYPASS = 1
) (
  input  logic          clk_Regs,
  input  logic          rst_n,
  reg_file_sb_if.slave  rf
);
  localparam int DEPTH = 2**ADDR_W;

  logic [DATA_W-1:0] mem_reg [DEPTH];
  logic [DATA_W-1:0] rd_port [NUM_RD];
  logic              wr_en;

  assign wr_en = rf.Reg_Write && (rf.W_Addr != ADDR_W'(ZERO_REG));

  always_ff @(posedge clk_Regs) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) mem_reg[i] <= '0;
    end else if (wr_en) begin
      mem_reg[rf.W_Addr] <= rf.W_Data;
    end
  end

  genvar gi;
  generate
    for (gi = 0; gi < NUM_RD; gi++) begin : g_rd
      logic [ADDR_W-1:0] ra;
      assign ra = rf.R_Addr[slice_lo(gi, ADDR_W) +: ADDR_W];
      always_comb begin
        rd_port[gi] = mem_reg[ra];
        if (ra == ADDR_W'(ZERO_REG))
          rd_port[gi] = '0;
        else if ((BYPASS != 0) && wr_en && (rf.W_Addr == ra))
          rd_port[gi] = rf.W_Data;
      end
    end
  endgenerate

  always_comb begin
    rf.R_Data = '0;
    for (int k = 0; k < NUM_RD; k++)
      rf.R_Data[slice_lo(k, DATA_W) +: DATA_W] = rd_port[k];
  end

  rf_scoreboard #(
    .ADDR_W (ADDR_W),
    .NUM_RD (NUM_RD),
    .BYPASS (BYPASS)
  ) u_sb (
    .clk_Regs   (clk_Regs),
    .rst_n      (rst_n),
    .wr_en      (wr_en),
    .w_addr     (rf.W_Addr),
    .claim      (rf.Claim),
    .claim_addr (rf.Claim_Addr),
    .r_addr     (rf.R_Addr),
    .claim_ack  (rf.Claim_Ack),
    .r_busy     (rf.R_Busy),
    .busy_cnt   (rf.Busy_Cnt)
  );
endmodule

// File: tb/tb_reg_file_sb.sv
// Checks bypass and non-bypass register files against an array/scoreboard reference model.
module tb_reg_file_sb;
  logic        clk_Regs = 1'b0;
  logic        rst_n;
  logic        reg_write;
  logic [4:0]  w_addr;
  logic [31:0] w_data;
  logic        claim;
  logic [4:0]  claim_addr;
  logic [4:0]  ra [2];

  int n_assert = 0;
  int n_fail   = 0;

  logic [31:0] mem_m  [32];
  bit          busy_m [32];

  always #5 clk_Regs = ~clk_Regs;

  reg_file_sb_if #(.DATA_W(32), .ADDR_W(5), .NUM_RD(2)) bus_b ();
  reg_file_sb_if #(.DATA_W(32), .ADDR_W(5), .NUM_RD(2)) bus_n ();

  assign bus_b.Reg_Write  = reg_write;
  assign bus_b.W_Addr     = w_addr;
  assign bus_b.W_Data     = w_data;
  assign bus_b.Claim      = claim;
  assign bus_b.Claim_Addr = claim_addr;
  assign bus_b.R_Addr     = {ra[1], ra[0]};
  assign bus_n.Reg_Write  = reg_write;
  assign bus_n.W_Addr     = w_addr;
  assign bus_n.W_Data     = w_data;
  assign bus_n.Claim      = claim;
  assign bus_n.Claim_Addr = claim_addr;
  assign bus_n.R_Addr     = {ra[1], ra[0]};

  reg_file_sb #(.DATA_W(32), .ADDR_W(5), .NUM_RD(2), .BYPASS(1)) dut_b (
    .clk_Regs (clk_Regs),
    .rst_n    (rst_n),
    .rf       (bus_b)
  );

  reg_file_sb #(.DATA_W(32), .ADDR_W(5), .NUM_RD(2), .BYPASS(0)) dut_n (
    .clk_Regs (clk_Regs),
    .rst_n    (rst_n),
    .rf       (bus_n)
  );

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_assert++;
    assert (got === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic drive(input bit rst_v, input bit we, input int wa, input logic [31:0] wd,
                       input bit cl, input int ca, input int r0, input int r1);
    rst_n      = ~rst_v;
    reg_write  = we;
    w_addr     = 5'(wa);
    w_data     = wd;
    claim      = cl;
    claim_addr = 5'(ca);
    ra[0]      = 5'(r0);
    ra[1]      = 5'(r1);
  endtask

  // One clock: check combinational outputs mid-cycle, advance the model, check Busy_Cnt.
  task automatic cycle(input bit do_comb);
    logic [31:0] ed_b, ed_n;
    bit          eb_b, eb_n, fwd, exp_ack;
    int          a, cnt;
    #1;
    exp_ack = claim && ((claim_addr == 0) ||
              !(busy_m[claim_addr] && !(reg_write && (w_addr == claim_addr))));
    if (do_comb) begin
      for (int k = 0; k < 2; k++) begin
        a    = int'(ra[k]);
        fwd  = reg_write && (w_addr != 0) && (int'(w_addr) == a);
        ed_n = (a == 0) ? 32'h0 : mem_m[a];
        ed_b = (a != 0 && fwd) ? w_data : ed_n;
        eb_n = (a != 0) && busy_m[a];
        eb_b = eb_n && !fwd;
        chk($sformatf("rdata%0d_byp r%0d", k, a), 64'(bus_b.R_Data[k*32 +: 32]), 64'(ed_b));
        chk($sformatf("rdata%0d_nobyp r%0d", k, a), 64'(bus_n.R_Data[k*32 +: 32]), 64'(ed_n));
        chk($sformatf("rbusy%0d_byp r%0d", k, a), 64'(bus_b.R_Busy[k]), 64'(eb_b));
        chk($sformatf("rbusy%0d_nobyp r%0d", k, a), 64'(bus_n.R_Busy[k]), 64'(eb_n));
      end
      if (rst_n) begin
        chk($sformatf("ack_byp r%0d", claim_addr), 64'(bus_b.Claim_Ack), 64'(exp_ack));
        chk($sformatf("ack_nobyp r%0d", claim_addr), 64'(bus_n.Claim_Ack), 64'(exp_ack));
      end
    end
    @(posedge clk_Regs);
    if (!rst_n) begin
      for (int i = 0; i < 32; i++) begin
        mem_m[i]  = 32'h0;
        busy_m[i] = 1'b0;
      end
    end else begin
      if (reg_write && w_addr != 0) begin
        mem_m[w_addr]  = w_data;
        busy_m[w_addr] = 1'b0;
      end
      if (exp_ack && claim_addr != 0) busy_m[claim_addr] = 1'b1;
    end
    cnt = 0;
    for (int i = 0; i < 32; i++) cnt += int'(busy_m[i]);
    #1;
    chk("busy_cnt_byp", 64'(bus_b.Busy_Cnt), 64'(cnt));
    chk("busy_cnt_nobyp", 64'(bus_n.Busy_Cnt), 64'(cnt));
    $display("t=%0t rst_n=%0b we=%0b w=r%0d:%h claim=%0b r%0d ra={%0d,%0d} cnt=%0d",
             $time, rst_n, reg_write, w_addr, w_data, claim, claim_addr, ra[1], ra[0], cnt);
  endtask

  initial begin
    for (int i = 0; i < 32; i++) begin
      mem_m[i]  = 32'h0;
      busy_m[i] = 1'b0;
    end
    // Power-up reset: contents are unknown until the first edge.
    drive(1, 0, 0, 0, 0, 0, 3, 5);
    cycle(0);
    drive(0, 0, 0, 0, 0, 0, 3, 5);                    cycle(1);

    // Write with same-cycle read, then read back after the edge.
    drive(0, 1, 7, 32'hDEADBEEF, 0, 0, 7, 0);         cycle(1);
    drive(0, 0, 0, 0, 0, 0, 7, 7);                    cycle(1);

    // Claim, WAW stall, release.
    drive(0, 0, 0, 0, 1, 9, 0, 9);                    cycle(1);
    drive(0, 0, 0, 0, 1, 9, 9, 9);                    cycle(1);
    drive(0, 1, 9, 32'h55, 0, 0, 9, 0);               cycle(1);
    drive(0, 0, 0, 0, 0, 0, 9, 9);                    cycle(1);

    // Simultaneous release and reclaim of r4.
    drive(0, 0, 0, 0, 1, 4, 4, 0);                    cycle(1);
    drive(0, 1, 4, 32'h12, 1, 4, 4, 4);               cycle(1);
    drive(0, 0, 0, 0, 0, 0, 4, 4);                    cycle(1);

    // Register 0 ignores writes and claims.
    drive(0, 1, 0, 32'hFFFFFFFF, 1, 0, 0, 0);         cycle(1);
    drive(0, 0, 0, 0, 0, 0, 0, 4);                    cycle(1);

    // Reset while r1..r3 busy, with a competing claim of r5.
    drive(0, 0, 0, 0, 1, 1, 1, 2);                    cycle(1);
    drive(0, 0, 0, 0, 1, 2, 1, 2);                    cycle(1);
    drive(0, 0, 0, 0, 1, 3, 3, 5);                    cycle(1);
    drive(1, 0, 0, 0, 1, 5, 5, 3);                    cycle(1);
    for (int i = 0; i < 16; i++) begin
      drive(0, 0, 0, 0, 0, 0, 2*i, 2*i+1);            cycle(1);
    end

    // Random traffic concentrated on a few registers to provoke hazards.
    for (int n = 0; n < 500; n++) begin
      drive(($urandom_range(0, 59) == 0),
            ($urandom_range(0, 1) == 1), $urandom_range(0, 7), $urandom(),
            ($urandom_range(0, 2) != 0), $urandom_range(0, 7),
            $urandom_range(0, 7), (n % 4 == 0) ? $urandom_range(0, 31) : $urandom_range(0, 7));
      cycle(1);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end
endmodule
